// File: rtl/fix_field_extractor_if.sv
// fix_field_extractor_if: byte-in / field-out handshake bundle for the FIX field splitter.
// The slave modport is the extractor's view; master is the producer/consumer side.
interface fix_field_extractor_if #(
  parameter int TAG_BYTES   = 4,
  parameter int VALUE_BYTES = 32
);
  logic [7:0]                       data_i;
  logic                             data_valid_i;
  logic                             data_ready_o;
  logic                             field_valid_o;
  logic                             field_ready_i;
  logic [8*TAG_BYTES-1:0]           tag_o;
  logic [$clog2(TAG_BYTES+1)-1:0]   tag_len_o;
  logic [8*VALUE_BYTES-1:0]         value_o;
  logic [$clog2(VALUE_BYTES+1)-1:0] value_len_o;
  logic                             start_of_header_o;
  logic                             end_of_body_o;
  logic                             overflow_o;
  logic                             malformed_o;
  logic                             checksum_err_o;
  modport slave (
    input  data_i, data_valid_i, field_ready_i,
    output data_ready_o, field_valid_o, tag_o, tag_len_o, value_o, value_len_o,
           start_of_header_o, end_of_body_o, overflow_o, malformed_o, checksum_err_o
  );
  modport master (
    output data_i, data_valid_i, field_ready_i,
    input  data_ready_o, field_valid_o, tag_o, tag_len_o, value_o, value_len_o,
           start_of_header_o, end_of_body_o, overflow_o, malformed_o, checksum_err_o
  );
endinterface

// File: rtl/fix_field_extractor.sv
// fix_field_extractor: splits a "tag=value<SOH>" byte stream into packed fields.
// Define FIX_CHECKSUM_EN to verify the tag-10 checksum against the running byte sum.
module fix_field_extractor #(
  parameter int         TAG_BYTES   = 4,
  parameter int         VALUE_BYTES = 32,
  parameter logic [7:0] SOH_CHAR    = 8'h01,
  parameter logic [7:0] EQ_CHAR     = 8'h3D
) (
  input logic                   clk,
  input logic                   rst,
  fix_field_extractor_if.slave  bus
);
  localparam int TLW = $clog2(TAG_BYTES+1);
  localparam int VLW = $clog2(VALUE_BYTES+1);
  localparam logic [TLW-1:0] TMAX = TLW'(TAG_BYTES);
  localparam logic [VLW-1:0] VMAX = VLW'(VALUE_BYTES);
  typedef enum logic [1:0] {S_TAG, S_VALUE, S_SKIP, S_OUT} state_t;
  state_t                   state_q, state_d;
  logic [8*TAG_BYTES-1:0]   tag_q, tag_d;
  logic [TLW-1:0]           tag_len_q, tag_len_d;
  logic [8*VALUE_BYTES-1:0] value_q, value_d;
  logic [VLW-1:0]           value_len_q, value_len_d;
  logic                     tag_ovf_q, tag_ovf_d, val_ovf_q, val_ovf_d, mal_q, mal_d;
  logic                     acc, out_hs, is_digit, is_soh, valid, tag8, tag10;
  assign valid    = state_q == S_OUT;
  assign acc      = bus.data_valid_i && !valid;
  assign out_hs   = valid && bus.field_ready_i;
  assign is_digit = bus.data_i >= 8'h30 && bus.data_i <= 8'h39;
  assign is_soh   = bus.data_i == SOH_CHAR;
  always_comb begin
    state_d     = state_q;
    tag_d       = tag_q;
    tag_len_d   = tag_len_q;
    value_d     = value_q;
    value_len_d = value_len_q;
    tag_ovf_d   = tag_ovf_q;
    val_ovf_d   = val_ovf_q;
    mal_d       = mal_q;
    if (out_hs) begin
      state_d     = S_TAG;
      tag_d       = '0;
      tag_len_d   = '0;
      value_d     = '0;
      value_len_d = '0;
      tag_ovf_d   = 1'b0;
      val_ovf_d   = 1'b0;
      mal_d       = 1'b0;
    end else if (acc) begin
      case (state_q)
        S_TAG:
          if (is_digit) begin
            if (tag_len_q < TMAX) begin
              tag_d[8*tag_len_q +: 8] = bus.data_i;
              tag_len_d = tag_len_q + TLW'(1);
            end else tag_ovf_d = 1'b1;
          end else if (bus.data_i == EQ_CHAR) begin
            state_d = S_VALUE;
            mal_d   = tag_len_q == '0;
          end else begin
            state_d = is_soh ? S_OUT : S_SKIP;
            mal_d   = 1'b1;
          end
        S_VALUE:
          if (is_soh) state_d = S_OUT;
          else if (value_len_q < VMAX) begin
            value_d[8*value_len_q +: 8] = bus.data_i;
            value_len_d = value_len_q + VLW'(1);
          end else val_ovf_d = 1'b1;
        S_SKIP: state_d = is_soh ? S_OUT : S_SKIP;
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_TAG;
      tag_q       <= '0;
      tag_len_q   <= '0;
      value_q     <= '0;
      value_len_q <= '0;
      tag_ovf_q   <= 1'b0;
      val_ovf_q   <= 1'b0;
      mal_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag_q       <= tag_d;
      tag_len_q   <= tag_len_d;
      value_q     <= value_d;
      value_len_q <= value_len_d;
      tag_ovf_q   <= tag_ovf_d;
      val_ovf_q   <= val_ovf_d;
      mal_q       <= mal_d;
    end
  end
  // Special tags are recognised only from a clean, complete tag.
  assign tag8  = !tag_ovf_q && !mal_q && tag_len_q == TLW'(1) && tag_q[7:0] == 8'h38;
  assign tag10 = !tag_ovf_q && !mal_q && tag_len_q == TLW'(2) && tag_q[15:0] == 16'h3031;
  assign bus.data_ready_o      = !valid;
  assign bus.field_valid_o     = valid;
  assign bus.tag_o             = tag_q;
  assign bus.tag_len_o         = tag_len_q;
  assign bus.value_o           = value_q;
  assign bus.value_len_o       = value_len_q;
  assign bus.start_of_header_o = valid && tag8;
  assign bus.end_of_body_o     = valid && tag10;
  assign bus.overflow_o        = tag_ovf_q || val_ovf_q;
  assign bus.malformed_o       = mal_q;
`ifdef FIX_CHECKSUM_EN
  logic [7:0] sum_q, sum_d, fsum_q, fsum_d;
  logic [9:0] ck_val;
  logic       ck_digits;
  // fsum covers the field in flight; sum holds completed fields since the last tag 8.
  assign fsum_d    = out_hs ? 8'h00 : acc ? fsum_q + bus.data_i : fsum_q;
  assign sum_d     = !out_hs ? sum_q : tag8 ? fsum_q : tag10 ? 8'h00 : sum_q + fsum_q;
  assign ck_digits = value_q[7:4] == 4'h3 && value_q[3:0] <= 4'd9 &&
                     value_q[15:12] == 4'h3 && value_q[11:8] <= 4'd9 &&
                     value_q[23:20] == 4'h3 && value_q[19:16] <= 4'd9;
  assign ck_val    = 10'(value_q[3:0]) * 10'd100 + 10'(value_q[11:8]) * 10'd10 + 10'(value_q[19:16]);
  always_ff @(posedge clk) begin
    if (!rst) begin
      sum_q  <= 8'h00;
      fsum_q <= 8'h00;
    end else begin
      sum_q  <= sum_d;
      fsum_q <= fsum_d;
    end
  end
  assign bus.checksum_err_o = valid && tag10 &&
    (value_len_q != VLW'(3) || val_ovf_q || !ck_digits || ck_val != {2'b00, sum_q});
`else
  assign bus.checksum_err_o = 1'b0;
`endif
endmodule

// File: tb/tb_fix_field_extractor.sv
// tb_fix_field_extractor: directed bench; a second DUT with VALUE_BYTES=4 sees the same
// stream to exercise value overflow. Define FIX_CHECKSUM_EN to also cover the checksum.
module tb_fix_field_extractor;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  fix_field_extractor_if #(.TAG_BYTES(4), .VALUE_BYTES(32)) m_if();
  fix_field_extractor_if #(.TAG_BYTES(4), .VALUE_BYTES(4))  s_if();
  fix_field_extractor #(.TAG_BYTES(4), .VALUE_BYTES(32)) dut   (.clk(clk), .rst(rst), .bus(m_if));
  fix_field_extractor #(.TAG_BYTES(4), .VALUE_BYTES(4))  dut_s (.clk(clk), .rst(rst), .bus(s_if));
  assign s_if.data_i        = m_if.data_i;
  assign s_if.data_valid_i  = m_if.data_valid_i;
  assign s_if.field_ready_i = m_if.field_ready_i;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    m_if.data_i = b;
    m_if.data_valid_i = 1'b1;
    while (!m_if.data_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_if.data_ready_o) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed ready 0 expected 1");
    end
    @(posedge clk); #1;
    m_if.data_valid_i = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_field(input string s);
    send_str(s);
    send_byte(8'h01);
  endtask

  task automatic take(input string tag);
    m_if.field_ready_i = 1'b1;
    @(posedge clk); #1;
    m_if.field_ready_i = 1'b0;
    chk({tag, "_valid_low"}, m_if.field_valid_o, 1'b0);
    chk({tag, "_ready_back"}, m_if.data_ready_o, 1'b1);
  endtask

  // flags packed as {sof, eob, overflow, malformed}
  function automatic logic [3:0] flags_m();
    return {m_if.start_of_header_o, m_if.end_of_body_o, m_if.overflow_o, m_if.malformed_o};
  endfunction

  initial begin
    m_if.data_i = 8'h00;
    m_if.data_valid_i = 1'b0;
    m_if.field_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", m_if.data_ready_o, 1'b1);
    chk("rst_valid", m_if.field_valid_o, 1'b0);
    chk("rst_tag", m_if.tag_o, 32'h0);
    chk("rst_vlen", m_if.value_len_o, 6'd0);
    chk("rst_flags", flags_m(), 4'b0000);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", m_if.data_ready_o, 1'b1);
    chk("idle_valid", m_if.field_valid_o, 1'b0);

    send_field("8=FIX.4.2");
    chk("hdr_valid", m_if.field_valid_o, 1'b1);
    chk("hdr_tlen", m_if.tag_len_o, 3'd1);
    chk("hdr_tag", m_if.tag_o, 32'h38);
    chk("hdr_vlen", m_if.value_len_o, 6'd7);
    chk("hdr_value", m_if.value_o, 56'h32_2E_34_2E_58_49_46);
    chk("hdr_flags", flags_m(), 4'b1000);
    m_if.data_i = 8'h41;
    m_if.data_valid_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_valid", m_if.field_valid_o, 1'b1);
      chk("stall_ready", m_if.data_ready_o, 1'b0);
      chk("stall_value", m_if.value_o, 56'h32_2E_34_2E_58_49_46);
    end
    m_if.field_ready_i = 1'b1;
    @(posedge clk); #1;
    m_if.field_ready_i = 1'b0;
    m_if.data_valid_i = 1'b0;
    chk("release_valid", m_if.field_valid_o, 1'b0);
    chk("release_tlen", m_if.tag_len_o, 3'd0);

    send_field("10=123");
    chk("eob_tag", m_if.tag_o, 32'h3031);
    chk("eob_tlen", m_if.tag_len_o, 3'd2);
    chk("eob_vlen", m_if.value_len_o, 6'd3);
    chk("eob_value", m_if.value_o, 24'h333231);
    chk("eob_flags", flags_m(), 4'b0100);
    take("eob");

    send_field("35=ABCDEF");
    chk("big_vlen", m_if.value_len_o, 6'd6);
    chk("big_value", m_if.value_o, 48'h464544434241);
    chk("big_flags", flags_m(), 4'b0000);
    chk("small_vlen", s_if.value_len_o, 3'd4);
    chk("small_value", s_if.value_o, 32'h44434241);
    chk("small_ovf", s_if.overflow_o, 1'b1);
    chk("small_mal", s_if.malformed_o, 1'b0);
    take("ovf");

    send_field("=X");
    chk("empty_tag_mal", m_if.malformed_o, 1'b1);
    chk("empty_tag_tlen", m_if.tag_len_o, 3'd0);
    take("empty_tag");

    send_field("3A=1");
    chk("bad_tag_flags", flags_m(), 4'b0001);
    chk("bad_tag_vlen", m_if.value_len_o, 6'd0);
    take("bad_tag");

    send_field("8=X");
    chk("clean_flags", flags_m(), 4'b1000);
    chk("clean_value", m_if.value_o, 8'h58);
    take("clean");

    send_byte(8'h01);
    chk("bare_soh_valid", m_if.field_valid_o, 1'b1);
    chk("bare_soh_mal", m_if.malformed_o, 1'b1);
    take("bare_soh");

    send_field("12345=Z");
    chk("long_tag_tlen", m_if.tag_len_o, 3'd4);
    chk("long_tag", m_if.tag_o, 32'h34333231);
    chk("long_tag_flags", flags_m(), 4'b0010);
    take("long_tag");

    send_field("108=30");
    chk("tag108_flags", flags_m(), 4'b0000);
    take("tag108");

    send_str("8=FI");
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_vlen", m_if.value_len_o, 6'd0);
    chk("midrst_tlen", m_if.tag_len_o, 3'd0);
    rst = 1'b1;
    send_field("10=5");
    chk("midrst_tag", m_if.tag_o, 32'h3031);
    chk("midrst_value", m_if.value_o, 8'h35);
    chk("midrst_flags", flags_m(), 4'b0100);
    take("midrst");

`ifdef FIX_CHECKSUM_EN
    send_field("8=A");
    chk("ck8_err", m_if.checksum_err_o, 1'b0);
    take("ck8a");
    send_field("10=183");
    chk("ck_good", m_if.checksum_err_o, 1'b0);
    take("ck_good");
    send_field("8=A");
    take("ck8b");
    send_field("10=184");
    chk("ck_bad", m_if.checksum_err_o, 1'b1);
    take("ck_bad");
    send_field("8=A");
    take("ck8c");
    send_field("10=18");
    chk("ck_short", m_if.checksum_err_o, 1'b1);
    take("ck_short");
`else
    send_field("10=000");
    chk("ck_off", m_if.checksum_err_o, 1'b0);
    take("ck_off");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
